// File: rtl/sha256_message_schedule.sv
// SHA-256 message schedule feeder: latches a 512-bit block and streams the
// 64 (W[t], K[t]) pairs one round at a time on a valid/ack handshake.
module sha256_message_schedule (
   input  logic         in_clk,
   input  logic         in_rst,
   input  logic [511:0] in_Block,
   input  logic         in_start,
   input  logic         in_ack,
   output logic [31:0]  out_Wi,
   output logic [31:0]  out_Ki,
   output logic [5:0]   out_round,
   output logic         out_valid,
   output logic         out_last,
   output logic         out_busy,
   output logic         out_done
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]  state_r;
   logic [31:0] w_r [0:15];
   logic [5:0]  round_r;
   logic        done_r;
   logic [31:0] w_new_s;
   logic [31:0] k_s;
   logic        run_s;

   // small sigma 0: ROTR7 ^ ROTR18 ^ SHR3
   function automatic logic [31:0] sigma0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   // small sigma 1: ROTR17 ^ ROTR19 ^ SHR10
   function automatic logic [31:0] sigma1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
   endfunction

   // Round constant ROM K[0..63]
   function automatic logic [31:0] k_rom(input logic [5:0] idx);
      logic [31:0] k;
      case (idx)
         6'd0:  k = 32'h428a2f98;  6'd1:  k = 32'h71374491;
         6'd2:  k = 32'hb5c0fbcf;  6'd3:  k = 32'he9b5dba5;
         6'd4:  k = 32'h3956c25b;  6'd5:  k = 32'h59f111f1;
         6'd6:  k = 32'h923f82a4;  6'd7:  k = 32'hab1c5ed5;
         6'd8:  k = 32'hd807aa98;  6'd9:  k = 32'h12835b01;
         6'd10: k = 32'h243185be;  6'd11: k = 32'h550c7dc3;
         6'd12: k = 32'h72be5d74;  6'd13: k = 32'h80deb1fe;
         6'd14: k = 32'h9bdc06a7;  6'd15: k = 32'hc19bf174;
         6'd16: k = 32'he49b69c1;  6'd17: k = 32'hefbe4786;
         6'd18: k = 32'h0fc19dc6;  6'd19: k = 32'h240ca1cc;
         6'd20: k = 32'h2de92c6f;  6'd21: k = 32'h4a7484aa;
         6'd22: k = 32'h5cb0a9dc;  6'd23: k = 32'h76f988da;
         6'd24: k = 32'h983e5152;  6'd25: k = 32'ha831c66d;
         6'd26: k = 32'hb00327c8;  6'd27: k = 32'hbf597fc7;
         6'd28: k = 32'hc6e00bf3;  6'd29: k = 32'hd5a79147;
         6'd30: k = 32'h06ca6351;  6'd31: k = 32'h14292967;
         6'd32: k = 32'h27b70a85;  6'd33: k = 32'h2e1b2138;
         6'd34: k = 32'h4d2c6dfc;  6'd35: k = 32'h53380d13;
         6'd36: k = 32'h650a7354;  6'd37: k = 32'h766a0abb;
         6'd38: k = 32'h81c2c92e;  6'd39: k = 32'h92722c85;
         6'd40: k = 32'ha2bfe8a1;  6'd41: k = 32'ha81a664b;
         6'd42: k = 32'hc24b8b70;  6'd43: k = 32'hc76c51a3;
         6'd44: k = 32'hd192e819;  6'd45: k = 32'hd6990624;
         6'd46: k = 32'hf40e3585;  6'd47: k = 32'h106aa070;
         6'd48: k = 32'h19a4c116;  6'd49: k = 32'h1e376c08;
         6'd50: k = 32'h2748774c;  6'd51: k = 32'h34b0bcb5;
         6'd52: k = 32'h391c0cb3;  6'd53: k = 32'h4ed8aa4a;
         6'd54: k = 32'h5b9cca4f;  6'd55: k = 32'h682e6ff3;
         6'd56: k = 32'h748f82ee;  6'd57: k = 32'h78a5636f;
         6'd58: k = 32'h84c87814;  6'd59: k = 32'h8cc70208;
         6'd60: k = 32'h90befffa;  6'd61: k = 32'ha4506ceb;
         6'd62: k = 32'hbef9a3f7;  6'd63: k = 32'hc67178f2;
         default: k = 32'h00000000;
      endcase
      return k;
   endfunction

   // Next schedule word W[t+16] from the current window (mod 2^32)
   always_comb begin
      w_new_s = sigma1(w_r[14]) + w_r[9] + sigma0(w_r[1]) + w_r[0];
   end

   // Constant lookup and RUN decode, both purely from registered state
   always_comb begin
      k_s = k_rom(round_r);
      if (state_r == ST_RUN) begin
         run_s = 1'b1;
      end else begin
         run_s = 1'b0;
      end
   end

   // FSM, round counter and sliding window; reset dominates start and ack
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state_r <= ST_IDLE;
         round_r <= 6'd0;
         done_r  <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            w_r[i] <= 32'h00000000;
         end
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (in_start) begin
                  for (int i = 0; i < 16; i++) begin
                     w_r[i] <= in_Block[511 - 32*i -: 32];
                  end
                  round_r <= 6'd0;
                  state_r <= ST_RUN;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_RUN: begin
               done_r <= 1'b0;
               if (in_ack) begin
                  // Window keeps expanding past W63; those words are never shown
                  for (int i = 0; i < 15; i++) begin
                     w_r[i] <= w_r[i+1];
                  end
                  w_r[15] <= w_new_s;
                  if (round_r == 6'd63) begin
                     round_r <= 6'd0;
                     done_r  <= 1'b1;
                     state_r <= ST_IDLE;
                  end else begin
                     round_r <= round_r + 6'd1;
                  end
               end else begin
                  state_r <= ST_RUN;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               round_r <= 6'd0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   // Output decode; Ki is zeroed outside RUN so every output reads 0 after reset
   always_comb begin
      out_Wi    = w_r[0];
      out_round = round_r;
      out_valid = run_s;
      out_busy  = run_s;
      out_done  = done_r;
      if (run_s) begin
         out_Ki   = k_s;
         out_last = (round_r == 6'd63);
      end else begin
         out_Ki   = 32'h00000000;
         out_last = 1'b0;
      end
   end

endmodule

// File: tb/tb_sha256_message_schedule.sv
// Self-checking bench for sha256_message_schedule: directed "abc" block runs
// with continuous ack, a stall, a start during RUN, reset mid-run and
// back-to-back starts.
module tb_sha256_message_schedule;

   logic         in_clk;
   logic         in_rst;
   logic [511:0] in_Block;
   logic         in_start;
   logic         in_ack;
   logic [31:0]  out_Wi;
   logic [31:0]  out_Ki;
   logic [5:0]   out_round;
   logic         out_valid;
   logic         out_last;
   logic         out_busy;
   logic         out_done;

   sha256_message_schedule dut (
      .in_clk   (in_clk),
      .in_rst   (in_rst),
      .in_Block (in_Block),
      .in_start (in_start),
      .in_ack   (in_ack),
      .out_Wi   (out_Wi),
      .out_Ki   (out_Ki),
      .out_round(out_round),
      .out_valid(out_valid),
      .out_last (out_last),
      .out_busy (out_busy),
      .out_done (out_done)
   );

   typedef struct {
      int          rnd;
      logic        chk_wi;
      logic [31:0] wi;
      logic [31:0] ki;
   } vec_t;

   vec_t        vecs [6];
   logic [31:0] w_ref [64];
   logic [511:0] abc_blk;
   logic [511:0] alt_blk;
   int          n_checks;
   int          n_pass;

   initial in_clk = 1'b0;
   always #5 in_clk = ~in_clk;

   function automatic logic [31:0] ss0(input logic [31:0] x);
      return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ss1(input logic [31:0] x);
      return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, required %h at time %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_idle(input string name);
      check({name, "_valid"}, 32'(out_valid), 32'd0);
      check({name, "_busy"},  32'(out_busy),  32'd0);
      check({name, "_last"},  32'(out_last),  32'd0);
      check({name, "_done"},  32'(out_done),  32'd0);
   endtask

   // One "abc" block; optional stall round, start-during-run round,
   // reset round, and back-to-back restart at the final accept.
   task automatic run_abc(input int stall_t, input int intr_t, input int rst_t, input bit b2b);
      int t;
      int stall_left;
      bit stall_used;
      logic ack_now;
      t = 0;
      stall_left = 0;
      stall_used = 1'b0;
      in_Block = abc_blk;
      in_start = 1'b1;
      in_ack   = 1'b1;
      @(negedge in_clk);
      in_start = 1'b0;
      while (t < 64) begin
         check("valid", 32'(out_valid), 32'd1);
         check("busy", 32'(out_busy), 32'd1);
         check("round", 32'(out_round), 32'(t));
         check("wi", out_Wi, w_ref[t]);
         check("last", 32'(out_last), (t == 63) ? 32'd1 : 32'd0);
         check("done_in_run", 32'(out_done), 32'd0);
         for (int v = 0; v < 6; v++) begin
            if (vecs[v].rnd == t) begin
               check("vec_ki", out_Ki, vecs[v].ki);
               if (vecs[v].chk_wi) begin
                  check("vec_wi", out_Wi, vecs[v].wi);
               end
            end
         end
         if (t == rst_t) begin
            in_rst = 1'b1;
            @(negedge in_clk);
            in_rst = 1'b0;
            check_idle("rst_mid");
            @(negedge in_clk);
            check_idle("rst_mid_after");
            return;
         end
         if ((t == intr_t) || (b2b && t == 63)) begin
            in_start = 1'b1;
            in_Block = alt_blk;
         end else begin
            in_start = 1'b0;
            in_Block = abc_blk;
         end
         if (t == stall_t && !stall_used) begin
            stall_used = 1'b1;
            stall_left = 5;
         end
         if (stall_left > 0) begin
            in_ack = 1'b0;
            stall_left--;
         end else begin
            in_ack = 1'b1;
         end
         ack_now = in_ack;
         @(negedge in_clk);
         if (ack_now) t++;
      end
      in_start = 1'b0;
      check("done_pulse", 32'(out_done), 32'd1);
      check("valid_after", 32'(out_valid), 32'd0);
      check("busy_after", 32'(out_busy), 32'd0);
      if (b2b) begin
         in_start = 1'b1;
         in_Block = alt_blk;
         @(negedge in_clk);
         in_start = 1'b0;
         check("b2b_valid", 32'(out_valid), 32'd1);
         check("b2b_round", 32'(out_round), 32'd0);
         check("b2b_wi", out_Wi, 32'hdeadbeef);
         check("b2b_ki", out_Ki, 32'h428a2f98);
         in_rst = 1'b1;
         @(negedge in_clk);
         in_rst = 1'b0;
         check_idle("b2b_rst");
      end else begin
         @(negedge in_clk);
         check("done_once", 32'(out_done), 32'd0);
      end
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      abc_blk  = {32'h61626380, 448'h0, 32'h00000018};
      alt_blk  = {16{32'hdeadbeef}};
      for (int i = 0; i < 16; i++) w_ref[i] = abc_blk[511 - 32*i -: 32];
      for (int i = 16; i < 64; i++)
         w_ref[i] = ss1(w_ref[i-2]) + w_ref[i-7] + ss0(w_ref[i-15]) + w_ref[i-16];
      vecs[0] = '{0,  1'b1, 32'h61626380, 32'h428a2f98};
      vecs[1] = '{15, 1'b1, 32'h00000018, 32'hc19bf174};
      vecs[2] = '{16, 1'b1, 32'h61626380, 32'he49b69c1};
      vecs[3] = '{17, 1'b1, 32'h000f0000, 32'hefbe4786};
      vecs[4] = '{20, 1'b0, 32'h00000000, 32'h2de92c6f};
      vecs[5] = '{63, 1'b1, 32'h12b1edeb, 32'hc67178f2};

      // Reset for two cycles, then ack pulses while idle
      in_rst = 1'b1; in_start = 1'b0; in_ack = 1'b0; in_Block = 512'h0;
      @(negedge in_clk);
      @(negedge in_clk);
      in_rst = 1'b0;
      check_idle("reset");
      check("reset_wi", out_Wi, 32'h0);
      check("reset_ki", out_Ki, 32'h0);
      check("reset_round", 32'(out_round), 32'd0);
      for (int i = 0; i < 4; i++) begin
         in_ack = (i % 2 == 0) ? 1'b1 : 1'b0;
         @(negedge in_clk);
         check_idle("idle_ack");
         check("idle_ack_round", 32'(out_round), 32'd0);
      end

      run_abc(-1, -1, -1, 1'b0);   // continuous ack
      run_abc(20, -1, -1, 1'b0);   // 5-cycle stall at t=20
      run_abc(-1, 10, -1, 1'b0);   // start during RUN ignored
      run_abc(-1, -1, 30, 1'b0);   // reset mid-run
      run_abc(-1, -1, -1, 1'b0);   // restart after reset
      run_abc(-1, -1, -1, 1'b1);   // back-to-back starts

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
